// File: rtl/rv32_exec_stage_if.sv
// Decode-buffer to exec-buffer bus for the RV32 execute stage, with its record types.
// master = upstream/downstream environment, slave = the execute stage itself.
interface rv32_exec_stage_if;
    typedef struct packed {
        logic [3:0]  alu_op;
        logic        is_branch;
        logic [2:0]  br_cond;      // funct3 encoding of the branch compare
        logic        is_load;
        logic        is_store;
        logic        is_div;
        logic        div_signed;
        logic        div_rem;
        logic        reg_write;
        logic [4:0]  rd;
        logic [31:0] imm;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        ctrl_t       decoded_instr;
        logic [31:0] op1;
        logic [31:0] op2;
    } decode_buffer_data_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        ctrl_t       decoded_instr;
        logic [31:0] wb_result;
        logic [31:0] mem_addr;
        logic [31:0] store_data;
        logic        br_taken;
    } exec_buffer_data_t;

    decode_buffer_data_t decode_data;
    logic                mem_stall;
    exec_buffer_data_t   exec_data;
    logic                stall;

    modport master (output decode_data, output mem_stall, input exec_data, input stall);
    modport slave  (input decode_data, input mem_stall, output exec_data, output stall);
endinterface

// File: rtl/rv32_exec_stage.sv
// RV32 execute stage: single-cycle ALU/branch/address plus a 32-step restoring divider.
// Optional RV_DIV_SHORTCUT_EN resolves divide-by-zero and signed overflow in one cycle.
module rv32_exec_stage #(
    parameter int DIV_ITERS = 32
) (
    input  logic             clk,
    input  logic             reset,
    rv32_exec_stage_if.slave bus
);
    localparam logic [31:0] RV_NOP = 32'h0000_0013;
    localparam int CNT_W = $clog2(DIV_ITERS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;
    localparam logic [3:0] ALU_LINK = 4'd11;

    logic [31:0] op1, op2, pc, imm;
    logic [3:0]  alu_op;
    logic [2:0]  br_cond;
    logic        is_branch, is_div, div_signed, div_rem;

    assign op1        = bus.decode_data.op1;
    assign op2        = bus.decode_data.op2;
    assign pc         = bus.decode_data.pc;
    assign imm        = bus.decode_data.decoded_instr.imm;
    assign alu_op     = bus.decode_data.decoded_instr.alu_op;
    assign br_cond    = bus.decode_data.decoded_instr.br_cond;
    assign is_branch  = bus.decode_data.decoded_instr.is_branch;
    assign is_div     = bus.decode_data.decoded_instr.is_div;
    assign div_signed = bus.decode_data.decoded_instr.div_signed;
    assign div_rem    = bus.decode_data.decoded_instr.div_rem;

    logic [31:0] alu_res;
    always_comb begin
        alu_res = op1 + op2;
        case (alu_op)
            ALU_SUB:  alu_res = op1 - op2;
            ALU_SLL:  alu_res = op1 << op2[4:0];
            ALU_SLT:  alu_res = {31'b0, $signed(op1) < $signed(op2)};
            ALU_SLTU: alu_res = {31'b0, op1 < op2};
            ALU_XOR:  alu_res = op1 ^ op2;
            ALU_SRL:  alu_res = op1 >> op2[4:0];
            ALU_SRA:  alu_res = 32'($signed(op1) >>> op2[4:0]);
            ALU_OR:   alu_res = op1 | op2;
            ALU_AND:  alu_res = op1 & op2;
            ALU_PASS: alu_res = op2;
            ALU_LINK: alu_res = pc + 32'd4;
            default:  ;
        endcase
    end

    logic br_hit;
    always_comb begin
        br_hit = 1'b0;
        case (br_cond)
            3'b000: br_hit = (op1 == op2);
            3'b001: br_hit = (op1 != op2);
            3'b100: br_hit = ($signed(op1) <  $signed(op2));
            3'b101: br_hit = ($signed(op1) >= $signed(op2));
            3'b110: br_hit = (op1 <  op2);
            3'b111: br_hit = (op1 >= op2);
            default: br_hit = 1'b0;
        endcase
    end

    logic        shortcut;
    logic [31:0] shortcut_res;
`ifdef RV_DIV_SHORTCUT_EN
    logic div_by_zero, div_ovf;
    assign div_by_zero  = (op2 == 32'd0);
    assign div_ovf      = div_signed && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
    assign shortcut     = is_div && (div_by_zero || div_ovf);
    assign shortcut_res = div_by_zero ? (div_rem ? op1 : 32'hFFFF_FFFF)
                                      : (div_rem ? 32'd0 : 32'h8000_0000);
`else
    assign shortcut     = 1'b0;
    assign shortcut_res = 32'd0;
`endif

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [31:0]      quo_reg, rem_reg, dvs_reg;
    logic             q_neg_reg, r_neg_reg, rem_sel_reg;
    logic             div_start, div_busy;

    assign div_start = (state_reg == S_IDLE) && is_div && !shortcut;
    assign div_busy  = div_start || (state_reg == S_RUN);
    assign bus.stall = bus.mem_stall | div_busy;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (div_start) state_next = S_RUN;
            S_RUN:   if (cnt_reg == '0) state_next = S_DONE;
            S_DONE:  if (!bus.mem_stall) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
    logic [32:0] trial;
    logic        fits;
    assign trial = {rem_reg, quo_reg[31]};
    assign fits  = (trial >= {1'b0, dvs_reg});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            dvs_reg     <= '0;
            q_neg_reg   <= 1'b0;
            r_neg_reg   <= 1'b0;
            rem_sel_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (div_start) begin
                quo_reg     <= (div_signed && op1[31]) ? -op1 : op1;
                dvs_reg     <= (div_signed && op2[31]) ? -op2 : op2;
                rem_reg     <= '0;
                cnt_reg     <= CNT_LAST;
                q_neg_reg   <= div_signed && (op1[31] ^ op2[31]) && (op2 != 32'd0);
                r_neg_reg   <= div_signed && op1[31];
                rem_sel_reg <= div_rem;
            end else if (state_reg == S_RUN) begin
                rem_reg <= fits ? 32'(trial - {1'b0, dvs_reg}) : trial[31:0];
                quo_reg <= {quo_reg[30:0], fits};
                if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    logic [31:0] div_res, wb_result;
    assign div_res = rem_sel_reg ? (r_neg_reg ? -rem_reg : rem_reg)
                                 : (q_neg_reg ? -quo_reg : quo_reg);

    always_comb begin
        wb_result = alu_res;
        if (state_reg == S_DONE) wb_result = div_res;
        else if (shortcut)       wb_result = shortcut_res;
    end

    // A NOP is an all-zero control word carrying the canonical addi x0,x0,0 encoding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.exec_data       <= '0;
            bus.exec_data.instr <= RV_NOP;
        end else if (!bus.mem_stall) begin
            if (div_busy) begin
                bus.exec_data       <= '0;
                bus.exec_data.instr <= RV_NOP;
            end else begin
                bus.exec_data.instr         <= bus.decode_data.instr;
                bus.exec_data.pc            <= pc;
                bus.exec_data.decoded_instr <= bus.decode_data.decoded_instr;
                bus.exec_data.wb_result     <= wb_result;
                bus.exec_data.mem_addr      <= op1 + imm;
                bus.exec_data.store_data    <= op2;
                bus.exec_data.br_taken      <= is_branch && br_hit;
            end
        end
    end
endmodule

// File: tb/tb_rv32_exec_stage.sv
// Self-checking bench for rv32_exec_stage: directed vector table, hand sequences, random ops vs model.
module tb_rv32_exec_stage;
    localparam logic [31:0] RV_NOP = 32'h0000_0013;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASS = 4'd10, ALU_LINK = 4'd11;
    localparam int DIV_CYC = 33;
`ifdef RV_DIV_SHORTCUT_EN
    localparam int SC_CYC = 0;
`else
    localparam int SC_CYC = 33;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rv32_exec_stage_if bus ();
    rv32_exec_stage #(.DIV_ITERS(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int fails = 0;
    logic [31:0] cur_pc = 32'h0000_1000;
    logic [31:0] cur_instr = 32'd0;
    logic [31:0] exp_addr = 32'd0;
    logic        exp_br = 1'b0;

    typedef struct {
        logic [3:0]  op;
        bit          dv, ds, dr;
        logic [31:0] a, b, exp;
        int          cyc;
    } vec_t;
    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
        end
    endtask

    function automatic bit ref_br(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        case (c)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] p);
        int sh = int'(b[4:0]);
        case (op)
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return a[31] ? ~((~a) >> sh) : (a >> sh);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            ALU_PASS: return b;
            ALU_LINK: return p + 32'd4;
            default:  return a + b;
        endcase
    endfunction

    function automatic logic [31:0] ref_div(input bit s, input bit r, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
        if (!s) return r ? a % b : a / b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : 32'h8000_0000;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return r ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    task automatic drive(input logic [3:0] op, input bit dv, input bit ds, input bit dr,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit br, input logic [2:0] bc, input logic [31:0] imm);
        cur_pc    = cur_pc + 32'd4;
        cur_instr = {cur_pc[29:0], 2'b11} ^ 32'h5A00_0000;
        bus.decode_data.instr         = cur_instr;
        bus.decode_data.pc            = cur_pc;
        bus.decode_data.op1           = a;
        bus.decode_data.op2           = b;
        bus.decode_data.decoded_instr = '0;
        bus.decode_data.decoded_instr.alu_op     = op;
        bus.decode_data.decoded_instr.is_div     = dv;
        bus.decode_data.decoded_instr.div_signed = ds;
        bus.decode_data.decoded_instr.div_rem    = dr;
        bus.decode_data.decoded_instr.is_branch  = br;
        bus.decode_data.decoded_instr.br_cond    = bc;
        bus.decode_data.decoded_instr.imm        = imm;
        bus.decode_data.decoded_instr.reg_write  = 1'b1;
        bus.decode_data.decoded_instr.rd         = cur_pc[6:2];
        exp_addr = a + imm;
        exp_br   = br && ref_br(bc, a, b);
    endtask

    // Called just after a rising edge with the operation freshly driven; ends just after the capture edge.
    task automatic wait_result(input string nm, input logic [31:0] exp_wb, input int exp_cyc);
        int n = 0;
        #1;
        while (bus.stall === 1'b1 && n < 80) begin
            n++;
            @(posedge clk);
            #1;
            if (n == 1) chk({nm, " bubble"}, bus.exec_data.instr, RV_NOP);
            #1;
        end
        chk({nm, " stall_cycles"}, 32'(n), 32'(exp_cyc));
        @(posedge clk);
        #1;
        chk({nm, " wb_result"}, bus.exec_data.wb_result, exp_wb);
        chk({nm, " pc"}, bus.exec_data.pc, cur_pc);
        chk({nm, " instr"}, bus.exec_data.instr, cur_instr);
        chk({nm, " mem_addr"}, bus.exec_data.mem_addr, exp_addr);
        chk({nm, " br_taken"}, {31'b0, bus.exec_data.br_taken}, {31'b0, exp_br});
        $display("%s: pc=%08h op1=%08h op2=%08h wb=%08h stall_cycles=%0d", nm, cur_pc,
                 bus.decode_data.op1, bus.decode_data.op2, bus.exec_data.wb_result, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{ALU_ADD,  0, 0, 0, 32'd5,          32'd7,          32'd12,         0};
        vecs[1]  = '{ALU_SUB,  0, 0, 0, 32'd5,          32'd7,          32'hFFFF_FFFE,  0};
        vecs[2]  = '{ALU_SLT,  0, 0, 0, 32'hFFFF_FFFF,  32'd1,          32'd1,          0};
        vecs[3]  = '{ALU_SLTU, 0, 0, 0, 32'hFFFF_FFFF,  32'd1,          32'd0,          0};
        vecs[4]  = '{ALU_SRA,  0, 0, 0, 32'h8000_0000,  32'd4,          32'hF800_0000,  0};
        vecs[5]  = '{ALU_ADD,  1, 0, 0, 32'd100,        32'd7,          32'd14,         DIV_CYC};
        vecs[6]  = '{ALU_ADD,  1, 0, 1, 32'd100,        32'd7,          32'd2,          DIV_CYC};
        vecs[7]  = '{ALU_ADD,  1, 1, 0, 32'hFFFF_FFEC,  32'd6,          32'hFFFF_FFFD,  DIV_CYC};
        vecs[8]  = '{ALU_ADD,  1, 1, 1, 32'hFFFF_FFEC,  32'd6,          32'hFFFF_FFFE,  DIV_CYC};
        vecs[9]  = '{ALU_ADD,  1, 1, 0, 32'd5,          32'd0,          32'hFFFF_FFFF,  SC_CYC};
        vecs[10] = '{ALU_ADD,  1, 1, 1, 32'd5,          32'd0,          32'd5,          SC_CYC};
        vecs[11] = '{ALU_ADD,  1, 1, 0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  SC_CYC};
        vecs[12] = '{ALU_ADD,  1, 1, 1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          SC_CYC};
        vecs[13] = '{ALU_ADD,  1, 0, 1, 32'd7,          32'd100,        32'd7,          DIV_CYC};
        vecs[14] = '{ALU_ADD,  1, 0, 0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  DIV_CYC};

        // Reset state
        bus.mem_stall = 1'b0;
        reset = 1'b1;
        drive(ALU_ADD, 0, 0, 0, 32'd5, 32'd7, 1'b0, 3'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset instr", bus.exec_data.instr, RV_NOP);
        chk("reset pc", bus.exec_data.pc, 32'd0);
        chk("reset wb_result", bus.exec_data.wb_result, 32'd0);
        chk("reset ctrl_is_nop", {31'b0, bus.exec_data.decoded_instr == '0}, 32'd1);
        chk("reset stall", {31'b0, bus.stall}, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].dv, vecs[i].ds, vecs[i].dr, vecs[i].a, vecs[i].b,
                  1'b0, 3'd0, 32'd0);
            wait_result($sformatf("vec%0d", i), vecs[i].exp, vecs[i].cyc);
        end

        // Asynchronous reset clears a live result without waiting for a clock edge
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset instr", bus.exec_data.instr, RV_NOP);
        chk("async_reset wb_result", bus.exec_data.wb_result, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset in the middle of a division discards it; the division restarts with full latency
        drive(ALU_ADD, 1, 0, 0, 32'd100, 32'd7, 1'b0, 3'd0, 32'd0);
        repeat (11) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst instr", bus.exec_data.instr, RV_NOP);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_result("midrst_restart", 32'd14, DIV_CYC);

        // Downstream stall while the divider is in its result cycle
        drive(ALU_ADD, 1, 0, 0, 32'd100, 32'd7, 1'b0, 3'd0, 32'd0);
        repeat (DIV_CYC) @(posedge clk);
        #1;
        chk("mstall done_stall", {31'b0, bus.stall}, 32'd0);
        bus.mem_stall = 1'b1;
        #1;
        chk("mstall stall_high", {31'b0, bus.stall}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("mstall frozen_instr%0d", k), bus.exec_data.instr, RV_NOP);
            chk($sformatf("mstall frozen_wb%0d", k), bus.exec_data.wb_result, 32'd0);
            chk($sformatf("mstall stall%0d", k), {31'b0, bus.stall}, 32'd1);
        end
        bus.mem_stall = 1'b0;
        #1;
        chk("mstall release_stall", {31'b0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("mstall wb_result", bus.exec_data.wb_result, 32'd14);
        chk("mstall pc", bus.exec_data.pc, cur_pc);
        drive(ALU_ADD, 0, 0, 0, 32'd1, 32'd2, 1'b0, 3'd0, 32'd0);
        wait_result("mstall_after", 32'd3, 0);

        // Randomized mix of ALU, branch and divide operations
        for (int t = 0; t < 50; t++) begin
            logic [31:0] a, b, imm;
            logic [3:0]  op;
            logic [2:0]  bc;
            bit          dv, ds, dr, br, special;
            int          mode;
            logic [2:0]  conds[6];
            conds = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            imm = $urandom;
            op  = 4'($urandom_range(0, 11));
            bc  = conds[$urandom_range(0, 5)];
            br  = 1'($urandom_range(0, 1));
            dv  = ($urandom_range(0, 4) == 0);
            ds  = 1'($urandom_range(0, 1));
            dr  = 1'($urandom_range(0, 1));
            if (dv) begin
                mode = $urandom_range(0, 4);
                if (mode == 0) b = 32'd0;
                else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; ds = 1'b1; end
                else if (mode == 2) begin a = $urandom_range(0, 1000); b = $urandom_range(1, 40); end
                special = (b == 32'd0) || (ds && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
                drive(op, 1'b1, ds, dr, a, b, br, bc, imm);
                wait_result($sformatf("rnd%0d_div", t), ref_div(ds, dr, a, b), special ? SC_CYC : DIV_CYC);
            end else begin
                drive(op, 1'b0, 1'b0, 1'b0, a, b, br, bc, imm);
                wait_result($sformatf("rnd%0d_alu", t), ref_alu(op, a, b, cur_pc), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/rv32_exec_stage.md
Name: rv32_exec_stage

Overview:
- Execute stage of the 5-stage RV32 pipeline. Sits between the decode buffer and the memory stage.
- Computes the integer ALU result and address in one cycle.
- Contains an iterative radix-2 divider (DIV/DIVU/REM/REMU) that stalls upstream while it runs.
- Registers its output into the exec buffer consumed by the memory stage.

Parameters:
- DIV_ITERS, 32, number of divider iterations (one quotient bit per cycle); fixed at XLEN.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- decode_data  in  decode_buffer_data_t  instr, pc, decoded_instr, forwarded op1/op2 values.
- mem_stall  in  1  downstream memory stage cannot accept; freeze exec buffer.
- exec_data  out  exec_buffer_data_t  registered result to memory stage.
- stall  out  1  combinational; upstream must hold decode_data while high.

Behaviour:
- Reset (async, active-high):
  - exec_data.instr=RV_NOP, pc=0, decoded_instr=create_nop_ctrl(), wb_result=0.
  - Divider FSM goes to IDLE, counter cleared.
- Single-cycle ops (ALU, branch compare, address gen):
  - Result is combinational from decode_data.
  - Captured into exec_data at the next edge when stall=0 and mem_stall=0.
- stall = mem_stall | div_busy.
- div_busy = 1 in these cases:
  - IDLE with a div-class op on decode_data.
  - Every RUN cycle.
- div_busy = 0 in DONE.
- Divider FSM:
  - IDLE:
    - On a div-class op, latch |op1|, |op2|, quotient/remainder sign flags and the rem/div select.
    - Set counter=DIV_ITERS-1 and go to RUN.
    - Other ops stay in IDLE.
  - RUN:
    - Each cycle: restoring shift-subtract step, one quotient bit.
    - When counter=0, go to DONE; otherwise decrement.
  - DONE:
    - Sign-corrected result drives wb_result.
    - When mem_stall=0, exec_data captures the instruction with that result and the FSM goes to IDLE.
    - When mem_stall=1, stay in DONE and hold the result.
- Latency: a div presented in cycle C holds stall for cycles C..C+32. The result is written to exec_data at the end of C+33 (34 cycles total, mem_stall=0).
- Bubble rule: while div_busy=1 and mem_stall=0, exec_data is loaded with a NOP (fields as at reset).
- mem_stall=1 overrides everything: exec_data holds its value and the FSM does not advance out of DONE. RUN keeps iterating, because the divider is internal state.
- RISC-V M semantics (32-bit, two's complement):
  - Divide by zero: quotient=0xFFFFFFFF, remainder=op1.
  - Overflow 0x80000000 / 0xFFFFFFFF (signed): quotient=0x80000000, remainder=0.
  - Signed: quotient is negative iff the operand signs differ and the divisor is nonzero. The remainder takes the sign of the dividend.
  - These cases still run the full iteration count unless the optional feature is enabled.
- Reset mid-division: the FSM returns to IDLE and the partial result is discarded. After reset release, the div still on decode_data restarts from IDLE.
- No new div may start in the DONE cycle. Back-to-back divs each take the full latency.

Optional Feature:
- RV_DIV_SHORTCUT_EN:
  - Defined: in IDLE, divisor==0 or the signed-overflow case produces the result combinationally with div_busy=0. It is captured like a single-cycle op, 1 cycle total, and the FSM never leaves IDLE.
  - Undefined: these cases take the full 34-cycle path, with identical results.

Test Plan:
- ADD op1=5, op2=7, mem_stall=0 → stall=0; exec_data.wb_result=12 one edge later; pc forwarded unchanged.
- DIVU 100/7 → stall high for 33 cycles; exec_data.wb_result=14 after edge 34; REMU 100/7 → 2.
- DIV 0xFFFFFFEC(-20) / 6 → quotient 0xFFFFFFFD(-3); REM same operands → 0xFFFFFFFE(-2).
- DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0. With RV_DIV_SHORTCUT_EN, each completes in 1 cycle with stall=0.
- DIVU 100/7 with mem_stall=1 asserted in DONE for 3 cycles → exec_data frozen, stall=1. After release, wb_result=14 is captured and the FSM returns to IDLE.
- Assert reset at RUN cycle 10 → exec_data=NOP immediately (async), FSM IDLE. After release, the same DIVU restarts and yields 14 after 34 cycles.
